// File: rtl/count_seq_pkg.sv
// count_seq_pkg: shared state encoding and limits for the count sequencer.
package count_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Largest legal prescale; the prescaler register is sized to hold DIV_MAX-1.
  localparam int DIV_MAX   = 255;
  localparam int PRE_W     = 8;
  localparam int W_DEFAULT = 4;

endpackage

// File: rtl/count_seq_tick.sv
// count_seq_tick: prescaler for the decrement strobe.
// Counts 0..DIV-1 while enabled and flags the last count as a tick.
module count_seq_tick
  import count_seq_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [PRE_W-1:0] LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q;

  assign tick = enable && (pre_q == LAST);

  // Prescaler: cleared before RUN, wraps to 0 on each tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else if (clear) begin
      pre_q <= '0;
    end else if (enable) begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: drives the load/decrement side of a down-counter.
// Optional count check enabled with `define COUNT_SEQ_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | latch strobe, counter takes cnt_in
// SETTLE | counter holds the load value; zero decides RUN or DONE
// RUN    | prescaled dec pulses until zero
// DONE   | one-cycle completion pulse
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int W   = W_DEFAULT,
  parameter int DIV = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [W-1:0] load_val,
  input  logic         abort,
  input  logic         zero,
  output logic         latch,
  output logic [W-1:0] cnt_in,
  output logic         dec,
  output logic         busy,
  output logic         done,
  output logic         err
);

  state_t       state;
  state_t       state_nx;
  logic [W-1:0] val_q;
  logic         tick;

  count_seq_tick #(.DIV(DIV)) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == S_SETTLE),
    .enable  (state == S_RUN),
    .tick    (tick)
  );

  // Combinational so no decrement goes out in a cycle where zero is already high.
  assign dec    = (state == S_RUN) && tick && !zero && !abort;
  assign cnt_in = val_q;

  // Next-state decode; abort returns to IDLE from any busy state.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start && !abort) state_nx = S_LOAD;
      S_LOAD:   state_nx = abort ? S_IDLE : S_SETTLE;
      S_SETTLE: state_nx = abort ? S_IDLE : (zero ? S_DONE : S_RUN);
      S_RUN:    state_nx = abort ? S_IDLE : (zero ? S_DONE : S_RUN);
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State, captured load value and registered strobes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      val_q <= '0;
      latch <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      latch <= (state_nx == S_LOAD);
      busy  <= (state_nx != S_IDLE);
      done  <= (state_nx == S_DONE);
      if (state == S_IDLE && state_nx == S_LOAD) val_q <= load_val;
    end
  end

`ifdef COUNT_SEQ_CHECK_EN
  logic [W:0] step_q;

  // Step counter: number of dec pulses issued since the last load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      step_q <= '0;
    end else if (state == S_LOAD) begin
      step_q <= '0;
    end else if (dec) begin
      step_q <= step_q + 1'b1;
    end
  end

  assign err = (state == S_DONE) && (step_q != {1'b0, val_q});
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed checks of the count sequencer against a
// behavioural 4-bit down-counter, with DIV=1 and DIV=3 instances.
module tb_count_sequencer;

  logic clock = 1'b0;
  logic reset_n;

  // DIV=1 instance
  logic       start1, abort1, zero1, latch1, dec1, busy1, done1, err1, force1;
  logic [3:0] load1, cnt_in1, cnt1;
  // DIV=3 instance
  logic       start3, abort3, zero3, latch3, dec3, busy3, done3, err3;
  logic [3:0] load3, cnt_in3, cnt3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  count_sequencer #(.W(4), .DIV(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .load_val(load1),
    .abort(abort1), .zero(zero1), .latch(latch1), .cnt_in(cnt_in1),
    .dec(dec1), .busy(busy1), .done(done1), .err(err1)
  );

  count_sequencer #(.W(4), .DIV(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .start(start3), .load_val(load3),
    .abort(abort3), .zero(zero3), .latch(latch3), .cnt_in(cnt_in3),
    .dec(dec3), .busy(busy3), .done(done3), .err(err3)
  );

  // Counter models: load on latch, decrement on dec.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt1 <= '0;
      cnt3 <= '0;
    end else begin
      if (latch1) cnt1 <= cnt_in1;
      else if (dec1) cnt1 <= cnt1 - 1'b1;
      if (latch3) cnt3 <= cnt_in3;
      else if (dec3) cnt3 <= cnt3 - 1'b1;
    end
  end

  assign zero1 = (cnt1 == 4'd0) | force1;
  assign zero3 = (cnt3 == 4'd0);

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start1 = 0; abort1 = 0; load1 = 0; force1 = 0;
    start3 = 0; abort3 = 0; load3 = 0;
    #12;
    chk("rst_latch", latch1, 0);
    chk("rst_cnt_in", cnt_in1, 0);
    chk("rst_dec", dec1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_err", err1, 0);
    reset_n = 1'b1;
    cyc();

    // DIV=1, load 2
    load1 = 4'd2; start1 = 1;
    cyc(); start1 = 0;                       // T+1
    chk("n2_latch_t1", latch1, 1);
    chk("n2_cnt_in_t1", cnt_in1, 2);
    chk("n2_busy_t1", busy1, 1);
    chk("n2_dec_t1", dec1, 0);
    cyc();                                   // T+2
    chk("n2_latch_t2", latch1, 0);
    chk("n2_dec_t2", dec1, 0);
    cyc(); chk("n2_dec_t3", dec1, 1);
    cyc(); chk("n2_dec_t4", dec1, 1);
    cyc(); chk("n2_dec_t5", dec1, 0); chk("n2_done_t5", done1, 0);
    cyc(); chk("n2_done_t6", done1, 1); chk("n2_err_t6", err1, 0);
    cyc(); chk("n2_busy_t7", busy1, 0); chk("n2_done_t7", done1, 0);
    chk("n2_cnt", cnt1, 0);
    chk("n2_cnt_in_hold", cnt_in1, 2);

    // DIV=1, load 0
    load1 = 4'd0; start1 = 1;
    cyc(); start1 = 0;
    chk("n0_latch_t1", latch1, 1);
    cyc(); chk("n0_dec_t2", dec1, 0);
    cyc(); chk("n0_done_t3", done1, 1); chk("n0_dec_t3", dec1, 0);
    chk("n0_zero", zero1, 1);
    cyc(); chk("n0_busy_t4", busy1, 0);

    // Abort in second RUN cycle, load 5
    load1 = 4'd5; start1 = 1;
    cyc(); start1 = 0;
    cyc();
    cyc(); chk("ab_dec_t3", dec1, 1);
    cyc(); abort1 = 1; #1;
    chk("ab_dec_t4", dec1, 0);
    cyc(); abort1 = 0;
    chk("ab_busy", busy1, 0);
    chk("ab_done", done1, 0);
    chk("ab_cnt", cnt1, 4);
    cyc(); chk("ab_done_next", done1, 0);

    // Normal completion after abort, load 1
    load1 = 4'd1; start1 = 1;
    cyc(); start1 = 0;
    chk("re_cnt_in", cnt_in1, 1);
    cyc();
    cyc(); chk("re_dec_t3", dec1, 1);
    cyc(); chk("re_dec_t4", dec1, 0);
    cyc(); chk("re_done_t5", done1, 1); chk("re_err", err1, 0);
    chk("re_cnt", cnt1, 0);
    cyc();

    // start held high: one operation, then re-accept only from IDLE
    load1 = 4'd1; start1 = 1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk($sformatf("hold_latch_t%0d", i), latch1, (i == 1) ? 8'd1 : 8'd0);
      chk($sformatf("hold_done_t%0d", i), done1, (i == 5) ? 8'd1 : 8'd0);
    end
    cyc(); chk("hold_busy_t6", busy1, 0);
    cyc(); chk("hold_latch_t7", latch1, 1);
    start1 = 0;
    for (int i = 0; i < 6; i++) cyc();
    chk("hold_idle", busy1, 0);

    // DIV=3, load 2: RUN at T+3, dec at T+5 and T+8, done at T+10
    load3 = 4'd2; start3 = 1;
    cyc(); start3 = 0;
    chk("d3_latch", latch3, 1);
    cyc();
    for (int i = 3; i <= 10; i++) begin
      cyc();
      chk($sformatf("d3_dec_t%0d", i), dec3, (i == 5 || i == 8) ? 8'd1 : 8'd0);
      chk($sformatf("d3_done_t%0d", i), done3, (i == 10) ? 8'd1 : 8'd0);
    end
    chk("d3_err", err3, 0);
    cyc(); chk("d3_busy", busy3, 0);
    chk("d3_cnt", cnt3, 0);

`ifdef COUNT_SEQ_CHECK_EN
    // zero forced high in second RUN cycle: one step vs load 4
    load1 = 4'd4; start1 = 1;
    cyc(); start1 = 0;
    cyc();
    cyc(); chk("ce_dec_t3", dec1, 1);
    cyc(); force1 = 1; #1;
    chk("ce_dec_t4", dec1, 0);
    cyc(); force1 = 0;
    chk("ce_done", done1, 1);
    chk("ce_err", err1, 1);
    cyc(); chk("ce_err_after", err1, 0);

    // normal count of 4
    load1 = 4'd4; start1 = 1;
    cyc(); start1 = 0;
    for (int i = 2; i <= 8; i++) begin
      cyc();
      chk($sformatf("cn_err_t%0d", i), err1, 0);
    end
    chk("cn_done", done1, 1);
    cyc();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
